prog_loader: RTL and testbench



---
 rtl/prog_loader.sv | 195 +++++++++++++++++++
 tb/tb_prog_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: serial program loader that writes host bytes into program RAM.
//
// A host shifts bytes in over a 3-wire link (sck, mosi, cs_n), MSB first.
// Each completed byte is written to RAM at consecutive addresses from 0. Every
// write is an address-load strobe followed by a data-write strobe on the
// shared RAM bus. The CPU is held while a frame is active.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   sck, mosi, cs_n   host serial link, asynchronous to clk
//   mem_addr_enable   RAM address-register load strobe
//   mem_write_enable  RAM write strobe
//   mem_bus_out       RAM bus drive: zero-extended address or data, else 0
//   cpu_hold          high while a load frame is active
//   done              high after a frame completes, until the next frame
//   overflow          frame carried more bytes than the RAM holds
//   byte_count        bytes written in the current/last frame
//   checksum          mod-2^WIDTH sum of the bytes written
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | after reset, waiting for the first cs_n fall
// SHIFT | frame active, collecting serial bits
// ADDR  | address strobe for the byte just received
// WRITE | data strobe; address, byte_count and checksum advance
// DONE  | frame closed, results held until the next cs_n fall

module prog_loader #(
    parameter int WIDTH         = 8,
    parameter int ADDRESS_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sck,
    input  logic                     mosi,
    input  logic                     cs_n,
    output logic                     mem_addr_enable,
    output logic                     mem_write_enable,
    output logic [WIDTH-1:0]         mem_bus_out,
    output logic                     cpu_hold,
    output logic                     done,
    output logic                     overflow,
    output logic [ADDRESS_WIDTH:0]   byte_count,
    output logic [WIDTH-1:0]         checksum
);

    localparam int BCW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        ADDR,
        WRITE,
        DONE
    } state_t;

    state_t                   state;
    logic [1:0]               sck_sync;
    logic [1:0]               mosi_sync;
    logic [1:0]               cs_sync;
    logic                     sck_prev;
    logic                     cs_prev;
    logic [WIDTH-1:0]         shift_reg;
    logic [WIDTH-1:0]         data_reg;
    logic [BCW-1:0]           bit_cnt;
    logic                     byte_ready;
    logic [ADDRESS_WIDTH-1:0] address;

    logic             sck_rise;
    logic             cs_fall;
    logic             cs_low;
    logic             in_frame;
    logic [WIDTH-1:0] shift_next;

    // cs_n synchronisers come out of reset at the idle (high) level so a host
    // already idling does not look like a frame edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
            sck_prev  <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[0], sck};
            mosi_sync <= {mosi_sync[0], mosi};
            cs_sync   <= {cs_sync[0], cs_n};
            sck_prev  <= sck_sync[1];
            cs_prev   <= cs_sync[1];
        end
    end

    assign sck_rise   = sck_sync[1] & ~sck_prev;
    assign cs_fall    = cs_prev & ~cs_sync[1];
    assign cs_low     = ~cs_sync[1];
    assign in_frame   = (state == SHIFT) || (state == ADDR) || (state == WRITE);
    assign shift_next = {shift_reg[WIDTH-2:0], mosi_sync[1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            shift_reg        <= '0;
            data_reg         <= '0;
            bit_cnt          <= '0;
            byte_ready       <= 1'b0;
            address          <= '0;
            mem_addr_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_bus_out      <= '0;
            cpu_hold         <= 1'b0;
            done             <= 1'b0;
            overflow         <= 1'b0;
            byte_count       <= '0;
            checksum         <= '0;
        end else begin
            mem_addr_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_bus_out      <= '0;

            // The shifter keeps running during ADDR/WRITE so a byte that
            // starts right behind the previous one is not lost. Host timing
            // guarantees byte_ready is consumed long before the next byte
            // can complete.
            if (in_frame && cs_low && sck_rise) begin
                if (bit_cnt == BCW'(WIDTH - 1)) begin
                    shift_reg  <= shift_next;
                    data_reg   <= shift_next;
                    bit_cnt    <= '0;
                    byte_ready <= 1'b1;
                end else begin
                    shift_reg  <= shift_next;
                    bit_cnt    <= bit_cnt + BCW'(1);
                end
            end

            case (state)
                IDLE, DONE: begin
                    if (cs_fall) begin
                        state      <= SHIFT;
                        shift_reg  <= '0;
                        bit_cnt    <= '0;
                        byte_ready <= 1'b0;
                        address    <= '0;
                        byte_count <= '0;
                        checksum   <= '0;
                        overflow   <= 1'b0;
                        done       <= 1'b0;
                        cpu_hold   <= 1'b1;
                    end
                end

                SHIFT: begin
                    // A completed byte is handled before a frame close so a
                    // byte finishing just ahead of the cs_n rise still lands.
                    if (byte_ready) begin
                        byte_ready <= 1'b0;
                        if (!byte_count[ADDRESS_WIDTH]) begin
                            state           <= ADDR;
                            mem_addr_enable <= 1'b1;
                            mem_bus_out     <= WIDTH'(address);
                        end else begin
                            overflow <= 1'b1;
                        end
                    end else if (!cs_low) begin
                        state    <= DONE;
                        cpu_hold <= 1'b0;
                        done     <= 1'b1;
                    end
                end

                ADDR: begin
                    state            <= WRITE;
                    mem_write_enable <= 1'b1;
                    mem_bus_out      <= data_reg;
                end

                WRITE: begin
                    address    <= address + ADDRESS_WIDTH'(1);
                    byte_count <= byte_count + (ADDRESS_WIDTH + 1)'(1);
                    checksum   <= checksum + data_reg;
                    if (cs_low) begin
                        state <= SHIFT;
                    end else begin
                        state    <= DONE;
                        cpu_hold <= 1'b0;
                        done     <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    localparam int W    = 8;
    localparam int AW   = 4;
    localparam int CAP  = 1 << AW;
    localparam int MAXB = 18;
    localparam int NVEC = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sck = 1'b0;
    logic          mosi = 1'b0;
    logic          cs_n = 1'b1;
    logic          mem_addr_enable;
    logic          mem_write_enable;
    logic [W-1:0]  mem_bus_out;
    logic          cpu_hold;
    logic          done;
    logic          overflow;
    logic [AW:0]   byte_count;
    logic [W-1:0]  checksum;

    prog_loader #(.WIDTH(W), .ADDRESS_WIDTH(AW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .sck              (sck),
        .mosi             (mosi),
        .cs_n             (cs_n),
        .mem_addr_enable  (mem_addr_enable),
        .mem_write_enable (mem_write_enable),
        .mem_bus_out      (mem_bus_out),
        .cpu_hold         (cpu_hold),
        .done             (done),
        .overflow         (overflow),
        .byte_count       (byte_count),
        .checksum         (checksum)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // RAM-side observer: latches the address strobe like the RAM address
    // register would and logs every write, checking bus protocol each cycle.
    int           wr_addr_q[$];
    int           wr_data_q[$];
    logic [W-1:0] ram_addr = '0;
    logic         prev_ae = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            n_checks++;
            if ((mem_addr_enable && mem_write_enable) ||
                (!mem_addr_enable && !mem_write_enable && mem_bus_out != '0) ||
                ((mem_addr_enable || mem_write_enable) && !cpu_hold) ||
                (mem_write_enable && !prev_ae) ||
                (prev_ae && !mem_write_enable)) begin
                n_fail++;
                $display("FAIL strobe_protocol @%0t: ae=%0b we=%0b bus=0x%0h hold=%0b prev_ae=%0b",
                         $time, mem_addr_enable, mem_write_enable, mem_bus_out, cpu_hold, prev_ae);
            end
            if (mem_addr_enable) ram_addr = mem_bus_out;
            if (mem_write_enable) begin
                wr_addr_q.push_back(int'(ram_addr));
                wr_data_q.push_back(int'(mem_bus_out));
            end
            prev_ae = mem_addr_enable;
        end else begin
            prev_ae = 1'b0;
        end
    end

    typedef struct {
        int               nbytes;
        logic [MAXB*W-1:0] data;
        int               tail;
        logic [W-1:0]     tail_val;
        int               lo;
        int               hi;
        bit               has_exp;
        int               exp_count;
        int               exp_sum;
        bit               exp_ovf;
    } vec_t;

    vec_t vecs[NVEC];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [W-1:0] v, input int nb, input int lo, input int hi);
        for (int i = 0; i < nb; i++) begin
            mosi = v[W-1-i];
            tick(lo);
            sck = 1'b1;
            tick(hi);
            sck = 1'b0;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " ae"},   32'(mem_addr_enable), 32'd0);
        chk({tag, " we"},   32'(mem_write_enable), 32'd0);
        chk({tag, " bus"},  32'(mem_bus_out), 32'd0);
        chk({tag, " hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " ovf"},  32'(overflow), 32'd0);
        chk({tag, " cnt"},  32'(byte_count), 32'd0);
        chk({tag, " sum"},  32'(checksum), 32'd0);
    endtask

    // Drives one frame, then compares the DUT against the reference model:
    // the first CAP whole bytes land at addresses 0.. in order, anything
    // beyond is dropped and flags overflow, trailing partial bits vanish.
    task automatic run_frame(input vec_t v, input string tag);
        int n_wr;
        int sum;
        int k;
        logic [W-1:0] b;
        wr_addr_q.delete();
        wr_data_q.delete();
        cs_n = 1'b0;
        tick(4);
        chk({tag, " start hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, " start done"}, 32'(done), 32'd0);
        chk({tag, " start cnt"},  32'(byte_count), 32'd0);
        chk({tag, " start sum"},  32'(checksum), 32'd0);
        chk({tag, " start ovf"},  32'(overflow), 32'd0);
        for (int i = 0; i < v.nbytes; i++) begin
            b = v.data[i*W +: W];
            send_bits(b, W, v.lo, v.hi);
        end
        if (v.tail > 0) send_bits(v.tail_val, v.tail, v.lo, v.hi);
        tick(v.lo);
        cs_n = 1'b1;
        k = 0;
        while (!done && k < 60) begin
            tick(1);
            k++;
        end
        chk({tag, " done"}, 32'(done), 32'd1);
        tick(2);

        n_wr = (v.nbytes < CAP) ? v.nbytes : CAP;
        sum = 0;
        for (int i = 0; i < n_wr; i++) sum += int'(v.data[i*W +: W]);
        sum = sum % (1 << W);
        chk({tag, " hold"},  32'(cpu_hold), 32'd0);
        chk({tag, " count"}, 32'(byte_count), 32'(n_wr));
        chk({tag, " sum"},   32'(checksum), 32'(sum));
        chk({tag, " ovf"},   32'(overflow), 32'(v.nbytes > CAP));
        chk({tag, " nwrites"}, 32'(wr_data_q.size()), 32'(n_wr));
        for (int i = 0; i < n_wr && i < wr_data_q.size(); i++) begin
            chk($sformatf("%s wr%0d addr", tag, i), 32'(wr_addr_q[i]), 32'(i));
            chk($sformatf("%s wr%0d data", tag, i), 32'(wr_data_q[i]), 32'(v.data[i*W +: W]));
        end
        if (v.has_exp) begin
            chk({tag, " tbl count"}, 32'(byte_count), 32'(v.exp_count));
            chk({tag, " tbl sum"},   32'(checksum), 32'(v.exp_sum));
            chk({tag, " tbl ovf"},   32'(overflow), 32'(v.exp_ovf));
        end
    endtask

    task automatic set_vec(input int idx, input int nb, input int tail, input int lo,
                           input int hi, input bit has_exp, input int ec, input int es,
                           input bit eo);
        vecs[idx].nbytes    = nb;
        vecs[idx].tail      = tail;
        vecs[idx].tail_val  = W'($urandom);
        vecs[idx].lo        = lo;
        vecs[idx].hi        = hi;
        vecs[idx].has_exp   = has_exp;
        vecs[idx].exp_count = ec;
        vecs[idx].exp_sum   = es;
        vecs[idx].exp_ovf   = eo;
        vecs[idx].data      = '0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int k;

        set_vec(0, 3, 0, 5, 5, 1'b1, 3, 'hC7, 1'b0);
        vecs[0].data[23:0] = 24'h7A2F1E;
        set_vec(1, 17, 0, 4, 5, 1'b1, 16, 'h88, 1'b1);
        for (int j = 0; j < 16; j++) vecs[1].data[j*W +: W] = W'(j + 1);
        vecs[1].data[16*W +: W] = 8'hFF;
        set_vec(2, 1, 5, 5, 4, 1'b1, 1, 'hE0, 1'b0);
        vecs[2].data[7:0] = 8'hE0;
        set_vec(3, 2, 0, 4, 4, 1'b1, 2, 'hFF, 1'b0);
        vecs[3].data[15:0] = 16'h55AA;
        set_vec(4, 0, 0, 4, 4, 1'b1, 0, 0, 1'b0);
        for (int i = 5; i < NVEC; i++) begin
            set_vec(i, int'($urandom_range(1, MAXB)), int'($urandom_range(0, W - 1)),
                    int'($urandom_range(4, 7)), int'($urandom_range(4, 7)), 1'b0, 0, 0, 1'b0);
            for (int j = 0; j < MAXB; j++) vecs[i].data[j*W +: W] = W'($urandom);
        end

        tick(3);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick(4);
        check_idle_outputs("post_reset");

        for (int i = 0; i < NVEC; i++) begin
            run_frame(vecs[i], $sformatf("vec%0d", i));
            tick(6);
        end

        // sck activity with cs_n high after an overflowing frame must be
        // ignored; the following frame must clear every result at cs_n fall.
        run_frame(vecs[1], "ovf_again");
        wr_data_q.delete();
        for (int i = 0; i < 12; i++) begin
            mosi = 1'(i);
            tick(4);
            sck = 1'b1;
            tick(4);
            sck = 1'b0;
        end
        tick(6);
        chk("idle_sck nwrites", 32'(wr_data_q.size()), 32'd0);
        chk("idle_sck done",    32'(done), 32'd1);
        chk("idle_sck count",   32'(byte_count), 32'(CAP));
        chk("idle_sck ovf",     32'(overflow), 32'd1);
        chk("idle_sck hold",    32'(cpu_hold), 32'd0);
        run_frame(vecs[0], "after_idle_sck");
        tick(6);

        // Reset pulsed during the write strobe of the second byte.
        wr_addr_q.delete();
        wr_data_q.delete();
        cs_n = 1'b0;
        tick(4);
        send_bits(8'h11, W, 4, 4);
        send_bits(8'h22, W, 4, 4);
        k = 0;
        while (!(mem_write_enable && byte_count == 1) && k < 40) begin
            tick(1);
            k++;
        end
        chk("rst_mid reached write2", 32'(mem_write_enable), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_mid async");
        cs_n = 1'b1;
        tick(4);
        check_idle_outputs("rst_mid held");
        chk("rst_mid nwrites", 32'(wr_data_q.size()), 32'd1);
        rst_n = 1'b1;
        tick(4);
        check_idle_outputs("rst_mid released");
        v = vecs[5];
        v.nbytes = 2;
        run_frame(v, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
